spi_master_param: RTL and testbench

- Parametrised full-duplex SPI master; successor to the fixed 8-bit single-slave transmitter.
- Adds generic word width, programmable SCK divider, all four CKP/CPH modes with MISO capture, multiple chip selects, and a BUSY/DONE handshake.
- Sits between a local controller (parallel word + ENABLE) and off-chip SPI slaves.

---
 rtl/spi_pkg.sv | 39 +++
 rtl/spi_clk_gen.sv | 50 +++++
 rtl/spi_master_param.sv | 185 ++++++++++++++++++
 tb/tb_spi_master_param.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and helpers for the parametrised SPI master:
//                one-hot state encodings, SPI mode constants and a clog2
//                helper usable in constant expressions.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // One-hot controller states
    typedef enum logic [3:0] {
        S_IDLE     = 4'b0001,
        S_SETUP    = 4'b0010,
        S_TRANSFER = 4'b0100,
        S_HOLD     = 4'b1000
    } spi_state_e;

    // SPI modes encoded as {CKP, CPH}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Ceiling log2; returns 0 for values <= 1
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : spi_clk_gen
//  Description : Half-period timer for the SPI master. While run is high it
//                raises tick for one cycle every DIV/2 cycles; the register
//                update on that cycle's closing edge is an SCK edge. lead
//                flags whether the edge about to happen is a leading (odd)
//                edge. Counter and phase are held cleared while run is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int DIV = 4
)(
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick,
    output logic lead
);

    localparam int                 C_HALF  = DIV / 2;
    localparam int                 C_CNT_W = (clog2(C_HALF) > 0) ? clog2(C_HALF) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(C_HALF - 1);

    logic [C_CNT_W-1:0] r_cnt;
    logic               r_phase;

    assign tick = run && (r_cnt == C_LAST);
    assign lead = ~r_phase;

    // Half-period counter and leading/trailing phase, cleared whenever idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!run) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (tick) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master_param.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_param
//  Description : Parametrised full-duplex SPI master. Word width, SCK
//                divider and chip-select count are parameters; all four
//                CKP/CPH modes are supported. A transfer is accepted from
//                IDLE on ENABLE, runs SETUP -> TRANSFER -> HOLD and ends
//                with a one-cycle DONE pulse carrying the received word.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_param
    import spi_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DIV    = 4,
    parameter  int NUM_CS = 1,
    localparam int CS_W   = (NUM_CS > 1) ? clog2(NUM_CS) : 1
)(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic              CKP,
    input  logic              CPH,
    input  logic [CS_W-1:0]   CS_SEL,
    input  logic [DATA_W-1:0] DATAINPUT,
    input  logic              MISO,
    output logic              MOSI,
    output logic              SCK,
    output logic [NUM_CS-1:0] CS,
    output logic [DATA_W-1:0] DATAOUT,
    output logic              BUSY,
    output logic              DONE
);

    localparam int                  C_EDGE_W    = clog2(2 * DATA_W) + 1;
    localparam logic [C_EDGE_W-1:0] C_LAST_EDGE = C_EDGE_W'(2 * DATA_W - 1);

    spi_state_e          r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_tx, w_tx_nxt;
    logic [DATA_W-1:0]   r_rx, w_rx_nxt;
    logic [DATA_W-1:0]   r_dout, w_dout_nxt;
    logic [C_EDGE_W-1:0] r_edge, w_edge_nxt;
    logic [NUM_CS-1:0]   r_cs, w_cs_nxt;
    logic                r_ckp, w_ckp_nxt;
    logic                r_cph, w_cph_nxt;
    logic                r_sck, w_sck_nxt;
    logic                r_mosi, w_mosi_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;

    logic [NUM_CS-1:0]   w_sel_dec;
    logic                w_sel_ok;
    logic                w_run;
    logic                w_tick;
    logic                w_lead;
    logic                w_last;
    logic                w_sample;

    assign w_run    = (r_state != S_IDLE);
    assign w_last   = (r_edge == C_LAST_EDGE);
    // Leading edge samples when CPH=0, trailing edge samples when CPH=1
    assign w_sample = w_lead ^ r_cph;
    assign w_sel_ok = (32'(CS_SEL) < NUM_CS);

    spi_clk_gen #(
        .DIV (DIV)
    ) u_clk_gen (
        .clk  (CLK),
        .rst  (RESET),
        .run  (w_run),
        .tick (w_tick),
        .lead (w_lead)
    );

    // Decode the requested slave index to a one-hot select
    always_comb begin
        w_sel_dec = '0;
        for (int i = 0; i < NUM_CS; i++) begin
            w_sel_dec[i] = (32'(CS_SEL) == i);
        end
    end

    // Next-state and next-output logic for the transfer controller
    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_rx_nxt    = r_rx;
        w_dout_nxt  = r_dout;
        w_edge_nxt  = r_edge;
        w_cs_nxt    = r_cs;
        w_ckp_nxt   = r_ckp;
        w_cph_nxt   = r_cph;
        w_sck_nxt   = r_sck;
        w_mosi_nxt  = r_mosi;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_sck_nxt = CKP;
                if (ENABLE && w_sel_ok) begin
                    w_ckp_nxt   = CKP;
                    w_cph_nxt   = CPH;
                    w_edge_nxt  = '0;
                    w_rx_nxt    = '0;
                    w_cs_nxt    = ~w_sel_dec;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_SETUP;
                    if (CPH) begin
                        w_tx_nxt = DATAINPUT;
                    end else begin
                        // CPH=0 presents the MSB before the first SCK edge
                        w_mosi_nxt = DATAINPUT[DATA_W-1];
                        w_tx_nxt   = {DATAINPUT[DATA_W-2:0], 1'b0};
                    end
                end
            end
            S_SETUP, S_TRANSFER: begin
                if (w_tick) begin
                    w_edge_nxt  = r_edge + 1'b1;
                    w_sck_nxt   = w_last ? r_ckp : ~r_sck;
                    w_state_nxt = w_last ? S_HOLD : S_TRANSFER;
                    if (w_sample) begin
                        w_rx_nxt = {r_rx[DATA_W-2:0], MISO};
                    end else if (r_cph || !w_last) begin
                        // CPH=0 already sent its last bit; skip the final trailing shift
                        w_mosi_nxt = r_tx[DATA_W-1];
                        w_tx_nxt   = {r_tx[DATA_W-2:0], 1'b0};
                    end
                end
            end
            S_HOLD: begin
                if (w_tick) begin
                    w_cs_nxt    = '1;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_dout_nxt  = r_rx;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer in flight
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_tx    <= '0;
            r_rx    <= '0;
            r_dout  <= '0;
            r_edge  <= '0;
            r_cs    <= '1;
            r_ckp   <= 1'b0;
            r_cph   <= 1'b0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            r_rx    <= w_rx_nxt;
            r_dout  <= w_dout_nxt;
            r_edge  <= w_edge_nxt;
            r_cs    <= w_cs_nxt;
            r_ckp   <= w_ckp_nxt;
            r_cph   <= w_cph_nxt;
            r_sck   <= w_sck_nxt;
            r_mosi  <= w_mosi_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign MOSI    = r_mosi;
    assign SCK     = r_sck;
    assign CS      = r_cs;
    assign DATAOUT = r_dout;
    assign BUSY    = r_busy;
    assign DONE    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_param
//  Description : Self-checking bench for spi_master_param. Three instances:
//                8-bit/DIV4/1 CS, 16-bit/DIV6/4 CS and 8-bit/DIV4/3 CS.
//                Stimulus queues expected DATAOUT and slave-received words;
//                a monitor pops and compares on every DONE pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_param;
    import spi_pkg::*;

    typedef struct packed {
        logic [15:0] dout;
        logic [15:0] srx;
    } exp_t;

    logic CLK;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cnt0   = 0;
    exp_t q0[$];
    exp_t q1[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- instance 0: DATA_W=8, DIV=4, NUM_CS=1 ----------------
    logic       en0, ckp0, cph0, miso0, mosi0, sck0, busy0, done0, loop0;
    logic [0:0] sel0, cs0;
    logic [7:0] din0, dout0;

    spi_master_param #(.DATA_W(8), .DIV(4), .NUM_CS(1)) dut0 (
        .CLK(CLK), .RESET(rst), .ENABLE(en0), .CKP(ckp0), .CPH(cph0),
        .CS_SEL(sel0), .DATAINPUT(din0), .MISO(miso0), .MOSI(mosi0),
        .SCK(sck0), .CS(cs0), .DATAOUT(dout0), .BUSY(busy0), .DONE(done0)
    );

    // ---------------- instance 1: DATA_W=16, DIV=6, NUM_CS=4 ---------------
    logic        en1, ckp1, cph1, miso1, mosi1, sck1, busy1, done1;
    logic [1:0]  sel1;
    logic [3:0]  cs1;
    logic [15:0] din1, dout1;

    spi_master_param #(.DATA_W(16), .DIV(6), .NUM_CS(4)) dut1 (
        .CLK(CLK), .RESET(rst), .ENABLE(en1), .CKP(ckp1), .CPH(cph1),
        .CS_SEL(sel1), .DATAINPUT(din1), .MISO(miso1), .MOSI(mosi1),
        .SCK(sck1), .CS(cs1), .DATAOUT(dout1), .BUSY(busy1), .DONE(done1)
    );

    // ---------------- instance 2: DATA_W=8, DIV=4, NUM_CS=3 ----------------
    logic       en2, ckp2, cph2, miso2, mosi2, sck2, busy2, done2;
    logic [1:0] sel2;
    logic [2:0] cs2;
    logic [7:0] din2, dout2;

    spi_master_param #(.DATA_W(8), .DIV(4), .NUM_CS(3)) dut2 (
        .CLK(CLK), .RESET(rst), .ENABLE(en2), .CKP(ckp2), .CPH(cph2),
        .CS_SEL(sel2), .DATAINPUT(din2), .MISO(miso2), .MOSI(mosi2),
        .SCK(sck2), .CS(cs2), .DATAOUT(dout2), .BUSY(busy2), .DONE(done2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- slave model for instance 0 ----------------
    logic [7:0] s_tx0, s_rx0, s_rep0;
    logic       s_miso0 = 1'b0;
    logic       s_ckp0, s_cph0, s_pcs0, s_psck0;

    always @(cs0 or sck0) begin
        if (cs0[0] === 1'b0 && s_pcs0 === 1'b1) begin
            s_tx0 = s_rep0;
            if (!s_cph0) begin
                s_miso0 = s_tx0[7];
                s_tx0   = {s_tx0[6:0], 1'b0};
            end
        end else if (cs0[0] === 1'b0 && sck0 !== s_psck0) begin
            if ((sck0 !== s_ckp0) ^ s_cph0) begin
                s_rx0 = {s_rx0[6:0], mosi0};
            end else begin
                s_miso0 = s_tx0[7];
                s_tx0   = {s_tx0[6:0], 1'b0};
            end
        end
        s_pcs0  = cs0[0];
        s_psck0 = sck0;
    end
    assign miso0 = loop0 ? mosi0 : s_miso0;

    // ---------------- slave model for instance 1 (on CS[2]) ----------------
    logic [15:0] s_tx1, s_rx1, s_rep1;
    logic        s_miso1 = 1'b0;
    logic        s_pcs1, s_psck1;

    always @(cs1 or sck1) begin
        if (cs1[2] === 1'b0 && s_pcs1 === 1'b1) begin
            s_tx1 = s_rep1;
            if (!cph1) begin
                s_miso1 = s_tx1[15];
                s_tx1   = {s_tx1[14:0], 1'b0};
            end
        end else if (cs1[2] === 1'b0 && sck1 !== s_psck1) begin
            if ((sck1 !== ckp1) ^ cph1) begin
                s_rx1 = {s_rx1[14:0], mosi1};
            end else begin
                s_miso1 = s_tx1[15];
                s_tx1   = {s_tx1[14:0], 1'b0};
            end
        end
        s_pcs1  = cs1[2];
        s_psck1 = sck1;
    end
    assign miso1 = s_miso1;

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        exp_t e;
        if (done0) begin
            cnt0++;
            if (q0.size() == 0) begin
                chk("dut0_unexpected_done", 32'(done0), 32'(0));
            end else begin
                e = q0.pop_front();
                chk("dut0_dataout", 32'(dout0), 32'(e.dout));
                chk("dut0_slave_rx", 32'(s_rx0), 32'(e.srx));
            end
        end
        if (done1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_done", 32'(done1), 32'(0));
            end else begin
                e = q1.pop_front();
                chk("dut1_dataout", 32'(dout1), 32'(e.dout));
                chk("dut1_slave_rx", 32'(s_rx1), 32'(e.srx));
            end
        end
        if (done2) begin
            chk("dut2_unexpected_done", 32'(done2), 32'(0));
        end
    end

    // One transfer on instance 0 with full timing checks (H=2, 8 bits)
    task automatic run0(input logic [7:0] d, input logic [7:0] rep,
                        input logic [1:0] mode, input logic lp);
        int   edges, first_k, done_k;
        logic prev;
        @(negedge CLK);
        {ckp0, cph0}     = mode;
        {s_ckp0, s_cph0} = mode;
        loop0  = lp;
        s_rep0 = rep;
        en0    = 1'b0;
        @(negedge CLK);
        chk("sck_idle_before", 32'(sck0), 32'(mode[1]));
        din0 = d;
        en0  = 1'b1;
        q0.push_back({(lp ? {8'h00, d} : {8'h00, rep}), {8'h00, d}});
        @(negedge CLK);
        // Acceptance edge has passed; disturb inputs, which must be ignored
        en0  = 1'b0;
        din0 = ~d;
        ckp0 = ~mode[1];
        cph0 = ~mode[0];
        chk("cs_low_at_t0", 32'(cs0), 32'(0));
        chk("busy_at_t0", 32'(busy0), 32'(1));
        prev    = sck0;
        edges   = 0;
        first_k = -1;
        done_k  = -1;
        for (int k = 1; k <= 60 && done_k < 0; k++) begin
            @(negedge CLK);
            if (k == 30) begin
                ckp0 = mode[1];
                cph0 = mode[0];
            end
            if (sck0 !== prev) begin
                edges++;
                if (first_k < 0) first_k = k;
            end
            prev = sck0;
            if (done0) begin
                done_k = k;
                chk("cs_high_at_done", 32'(cs0), 32'(1));
                chk("busy_low_at_done", 32'(busy0), 32'(0));
                chk("sck_idle_after", 32'(sck0), 32'(mode[1]));
            end
        end
        chk("first_sck_edge_k", 32'(first_k), 32'(2));
        chk("sck_edge_count", 32'(edges), 32'(16));
        chk("done_k", 32'(done_k), 32'(34));
    endtask

    logic [1:0] modes [4];
    int   edges1, fk1, tk1, dk1, cnt_before, seen;
    logic prev1;

    initial begin
        modes = '{MODE0, MODE1, MODE2, MODE3};
        rst = 1'b1;
        en0 = 1'b0; ckp0 = 1'b1; cph0 = 1'b0; sel0 = 1'b0; din0 = 8'h00; loop0 = 1'b0;
        s_ckp0 = 1'b0; s_cph0 = 1'b0; s_rep0 = 8'h00;
        en1 = 1'b0; ckp1 = 1'b0; cph1 = 1'b0; sel1 = 2'd0; din1 = 16'h0000; s_rep1 = 16'h0000;
        en2 = 1'b0; ckp2 = 1'b0; cph2 = 1'b0; sel2 = 2'd0; din2 = 8'h00; miso2 = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset values (CKP input held high to show SCK is forced low)
        chk("rst_sck", 32'(sck0), 32'(0));
        chk("rst_mosi", 32'(mosi0), 32'(0));
        chk("rst_cs", 32'(cs0), 32'(1));
        chk("rst_dataout", 32'(dout0), 32'(0));
        chk("rst_busy", 32'(busy0), 32'(0));
        chk("rst_done", 32'(done0), 32'(0));
        chk("rst_cs_dut1", 32'(cs1), 32'(4'hF));
        rst  = 1'b0;
        ckp0 = 1'b0;

        // Mode 0 loopback
        run0(8'hA5, 8'h00, MODE0, 1'b1);

        // All four modes against the slave model
        for (int m = 0; m < 4; m++) begin
            run0(8'hC3, 8'h3C, modes[m], 1'b0);
        end

        // 16-bit, DIV=6, slave 2
        @(negedge CLK);
        s_rep1 = 16'h1234;
        sel1   = 2'd2;
        din1   = 16'hBEEF;
        en1    = 1'b1;
        q1.push_back({16'h1234, 16'hBEEF});
        @(negedge CLK);
        en1  = 1'b0;
        din1 = 16'h0000;
        chk("dut1_cs_sel2", 32'(cs1), 32'(4'b1011));
        prev1 = sck1; edges1 = 0; fk1 = -1; tk1 = -1; dk1 = -1;
        for (int k = 1; k <= 130 && dk1 < 0; k++) begin
            @(negedge CLK);
            if (sck1 !== prev1) begin
                edges1++;
                if (edges1 == 1) fk1 = k;
                if (edges1 == 3) tk1 = k;
            end
            prev1 = sck1;
            if (k < 99 && !done1) begin
                if (cs1 !== 4'b1011) chk("dut1_cs_during", 32'(cs1), 32'(4'b1011));
            end
            if (done1) dk1 = k;
        end
        chk("dut1_first_edge_k", 32'(fk1), 32'(3));
        chk("dut1_sck_period", 32'(tk1 - fk1), 32'(6));
        chk("dut1_edge_count", 32'(edges1), 32'(32));
        chk("dut1_done_k", 32'(dk1), 32'(99));

        // ENABLE held high for three back-to-back transfers (mode 0 loopback)
        @(negedge CLK);
        {ckp0, cph0} = MODE0; {s_ckp0, s_cph0} = MODE0;
        loop0 = 1'b1;
        cnt_before = cnt0;
        din0 = 8'h11;
        en0  = 1'b1;
        q0.push_back({16'h0011, 16'h0011});
        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < 5 && !busy0; w++) @(negedge CLK);
            case (i)
                0: begin din0 = 8'h22; q0.push_back({16'h0022, 16'h0022}); end
                1: begin din0 = 8'h33; q0.push_back({16'h0033, 16'h0033}); end
                default: begin din0 = 8'h44; en0 = 1'b0; end
            endcase
            seen = 0;
            for (int w = 0; w < 60; w++) begin
                @(negedge CLK);
                if (done0) begin
                    seen = 1;
                    break;
                end
            end
            chk("b2b_done_seen", 32'(seen), 32'(1));
            chk("b2b_cs_high_at_done", 32'(cs0), 32'(1));
            if (i < 2) begin
                @(negedge CLK);
                chk("b2b_cs_gap_one_cycle", 32'(cs0), 32'(0));
            end
        end
        repeat (40) @(negedge CLK);
        chk("b2b_done_count", 32'(cnt0 - cnt_before), 32'(3));

        // Reset mid-transfer (mode 2 so SCK idles high before reset)
        @(negedge CLK);
        {ckp0, cph0} = MODE2; {s_ckp0, s_cph0} = MODE2;
        loop0  = 1'b0;
        s_rep0 = 8'hFF;
        din0   = 8'h81;
        en0    = 1'b1;
        @(negedge CLK);
        en0 = 1'b0;
        cnt_before = cnt0;
        repeat (9) @(negedge CLK);
        @(posedge CLK);
        #2 rst = 1'b1;
        #1;
        chk("midrst_cs", 32'(cs0), 32'(1));
        chk("midrst_sck", 32'(sck0), 32'(0));
        chk("midrst_busy", 32'(busy0), 32'(0));
        @(negedge CLK);
        rst = 1'b0;
        repeat (40) @(negedge CLK);
        chk("midrst_no_done", 32'(cnt0 - cnt_before), 32'(0));
        run0(8'h5A, 8'h96, MODE0, 1'b0);

        // Out-of-range chip select is ignored
        @(negedge CLK);
        sel2 = 2'd3;
        din2 = 8'hFF;
        en2  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            chk("badsel_busy", 32'(busy2), 32'(0));
            chk("badsel_cs", 32'(cs2), 32'(3'b111));
        end
        en2 = 1'b0;
        repeat (5) @(negedge CLK);

        chk("dut0_queue_empty", 32'(q0.size()), 32'(0));
        chk("dut1_queue_empty", 32'(q1.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
